// File: rtl/spi_slave_core.sv
// spi_slave_core
//   SPI slave with a configurable word width, all four CPOL/CPHA modes and
//   MSB- or LSB-first bit order. sclk, mosi and cs are synchronised into clk.
//   While cs stays low, several words can follow one another in a single frame.
//   Every received word produces a one-cycle rx_valid pulse. A frame that ends
//   part-way through a word produces a one-cycle frame_err pulse.
//
//   State table
//     state    | meaning
//     ---------+-----------------------------------------------------------
//     ST_IDLE  | no frame in progress; miso held at 0; sclk edges ignored
//     ST_SHIFT | cs asserted; shift words in and out on sclk edges
//
// Ports
//   clk        in   system clock (at least 4x sclk)
//   rst        in   asynchronous active-high reset
//   data_in    in   word returned to the master; read at each word start
//   ready      out  1 while no frame is in progress
//   rx_data    out  last complete word received from the master
//   rx_valid   out  one-cycle pulse when rx_data is updated
//   frame_err  out  one-cycle pulse when cs rises part-way through a word
//   miso       out  registered serial data to the master
//   mosi       in   serial data from the master
//   sclk       in   SPI clock
//   cs         in   chip select, active low
module spi_slave_core #(
    parameter int DATA_WIDTH  = 32,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit LSB_FIRST   = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  miso,
    input  logic                  mosi,
    input  logic                  sclk,
    input  logic                  cs
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync, mosi_sync, cs_sync;
    logic                    sclk_prev;
    logic                    sclk_s, mosi_s, cs_s;
    logic                    leading, trailing, sample_edge, drive_edge;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_data_d;
    logic                    rx_valid_d, frame_err_d, miso_d;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d);
        return LSB_FIRST ? d[0] : d[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] d);
        return LSB_FIRST ? (d >> 1) : (d << 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] r,
                                                       input logic b);
        return LSB_FIRST ? {b, r[DATA_WIDTH-1:1]} : {r[DATA_WIDTH-2:0], b};
    endfunction

    // Reset values match the idle bus, so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_prev <= CPOL;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    // Leading edge leaves the idle level; trailing edge returns to it.
    assign leading     = (sclk_prev == CPOL) && (sclk_s != CPOL);
    assign trailing    = (sclk_prev != CPOL) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trailing : leading;
    assign drive_edge  = CPHA ? leading  : trailing;

    assign ready = (state_q == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            miso       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            frame_err  <= frame_err_d;
            miso       <= miso_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        miso_d      = miso;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (!cs_s) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    // In CPHA=0 the master samples the first bit on the first
                    // sclk edge, so that bit is driven as soon as cs falls.
                    if (!CPHA) begin
                        miso_d     = first_bit(data_in);
                        tx_shift_d = shift_out(data_in);
                    end
                end
            end

            ST_SHIFT: begin
                if (sample_edge) begin
                    rx_shift_d = shift_in(rx_shift_q, mosi_s);
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (drive_edge) begin
                    if (bit_cnt_q == '0) begin
                        miso_d     = first_bit(data_in);
                        tx_shift_d = shift_out(data_in);
                    end else begin
                        miso_d     = first_bit(tx_shift_q);
                        tx_shift_d = shift_out(tx_shift_q);
                    end
                end

                // The sample is handled first, so a final edge arriving with
                // cs rise completes the word and ends the frame cleanly.
                if (cs_s) begin
                    state_d     = ST_IDLE;
                    miso_d      = 1'b0;
                    frame_err_d = (bit_cnt_d != '0);
                    bit_cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_slave_core.sv
module tb_spi_slave_core;

    // inst 0: 8-bit mode 0 MSB-first, inst 1: 32-bit mode 3, inst 2: 8-bit mode 1 LSB-first
    localparam logic [2:0] CPOL_V = 3'b010;
    localparam logic [2:0] CPHA_V = 3'b110;
    localparam logic [2:0] LSB_V  = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk_m, cs_m, mosi_m;
    int          sel;
    logic [31:0] din       [3];
    logic [31:0] rx_data_w [3];
    logic        rx_valid_w[3];
    logic        frame_err_w[3];
    logic        miso_w    [3];
    logic        ready_w   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DW = (g == 1) ? 32 : 8;
        logic [DW-1:0] din_l, rxd_l;
        logic          cs_l, sclk_l;
        assign din_l        = din[g][DW-1:0];
        assign cs_l         = (sel == g) ? cs_m : 1'b1;
        assign sclk_l       = (sel == g) ? sclk_m : CPOL_V[g];
        assign rx_data_w[g] = 32'(rxd_l);
        spi_slave_core #(
            .DATA_WIDTH (DW),
            .CPOL       (CPOL_V[g]),
            .CPHA       (CPHA_V[g]),
            .LSB_FIRST  (LSB_V[g]),
            .SYNC_STAGES(2)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .data_in  (din_l),
            .ready    (ready_w[g]),
            .rx_data  (rxd_l),
            .rx_valid (rx_valid_w[g]),
            .frame_err(frame_err_w[g]),
            .miso     (miso_w[g]),
            .mosi     (mosi_m),
            .sclk     (sclk_l),
            .cs       (cs_l)
        );
    end

    // Reference model: words the master has fully clocked out, with the cycle
    // at which the slave must report them, plus expected abort pulses.
    typedef struct { int g; logic [31:0] w; int due; } rx_exp_t;
    typedef struct { int g; int due; } err_exp_t;
    rx_exp_t     rxq[$];
    err_exp_t    errq[$];
    logic [31:0] model_rxd[3];
    int          cyc = 0;
    int          total = 0, bad = 0;
    int          nvalid = 0, nerr = 0;

    logic [31:0] tx_w [4];
    logic [31:0] din_w[4];
    logic [31:0] rd_w [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare process: sampled 1 ns after every active edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            for (int g = 0; g < 3; g++) begin
                if (rx_valid_w[g]) begin
                    nvalid++;
                    if (rxq.size() == 0 || rxq[0].g != g) begin
                        total++; bad++;
                        $display("FAIL rx_valid_spurious inst %0d: got 1 expected 0 (cycle %0d)", g, cyc);
                    end else begin
                        chk("rx_word", rx_data_w[g], rxq[0].w);
                        chk("rx_latency", cyc, rxq[0].due);
                        model_rxd[g] = rxq[0].w;
                        void'(rxq.pop_front());
                    end
                end
                if (frame_err_w[g]) begin
                    nerr++;
                    if (errq.size() == 0 || errq[0].g != g) begin
                        total++; bad++;
                        $display("FAIL frame_err_spurious inst %0d: got 1 expected 0 (cycle %0d)", g, cyc);
                    end else begin
                        chk("err_latency", cyc, errq[0].due);
                        void'(errq.pop_front());
                    end
                end
                chk("rx_hold", rx_data_w[g], model_rxd[g]);
            end
            if (rxq.size() > 0 && rxq[0].due < cyc) begin
                total++; bad++;
                $display("FAIL rx_valid_missing inst %0d: got 0 expected 1 (due %0d)", rxq[0].g, rxq[0].due);
                void'(rxq.pop_front());
            end
            if (errq.size() > 0 && errq[0].due < cyc) begin
                total++; bad++;
                $display("FAIL frame_err_missing inst %0d: got 0 expected 1 (due %0d)", errq[0].g, errq[0].due);
                void'(errq.pop_front());
            end
        end
    end

    // SPI master: nw full words, optionally followed by an aborted word of
    // abort_bits bits; cs_last raises cs together with the final sample edge.
    task automatic frame(input int g, input int nw, input int abort_bits, input bit cs_last);
        int          dw, nb, nwt, idx, nidx;
        bit          cpol, cpha, lsb;
        logic [31:0] mask;
        dw   = (g == 1) ? 32 : 8;
        cpol = CPOL_V[g];
        cpha = CPHA_V[g];
        lsb  = LSB_V[g];
        mask = (dw == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
        nwt  = nw + ((abort_bits > 0) ? 1 : 0);
        @(negedge clk);
        sclk_m = cpol;
        sel    = g;
        din[g] = din_w[0];
        mosi_m = tx_w[0][lsb ? 0 : dw - 1];
        wait_n(4);
        cs_m = 1'b0;
        wait_n(8);
        chk("ready_busy", ready_w[g], 1'b0);
        for (int i = 0; i < nwt; i++) begin
            nb = (i == nw) ? abort_bits : dw;
            rd_w[i] = '0;
            for (int b = 0; b < nb; b++) begin
                idx = lsb ? b : dw - 1 - b;
                if (!cpha) begin
                    sclk_m = ~cpol;
                    rd_w[i][idx] = miso_w[g];
                    if (i < nw && b == dw - 1) begin
                        rxq.push_back('{g, tx_w[i] & mask, cyc + 3});
                        if (i + 1 < nwt) din[g] = din_w[i + 1];
                    end
                    wait_n(4);
                    sclk_m = cpol;
                    if (b + 1 < nb) begin
                        nidx   = lsb ? b + 1 : dw - 2 - b;
                        mosi_m = tx_w[i][nidx];
                    end else if (i + 1 < nwt) begin
                        mosi_m = tx_w[i + 1][lsb ? 0 : dw - 1];
                    end
                    wait_n(4);
                end else begin
                    sclk_m = ~cpol;
                    mosi_m = tx_w[i][idx];
                    wait_n(4);
                    sclk_m = cpol;
                    rd_w[i][idx] = miso_w[g];
                    if (i < nw && b == dw - 1) begin
                        rxq.push_back('{g, tx_w[i] & mask, cyc + 3});
                        if (i + 1 < nwt) din[g] = din_w[i + 1];
                        if (cs_last && i == nw - 1 && abort_bits == 0) cs_m = 1'b1;
                    end
                    wait_n(4);
                end
            end
            if (i < nw) chk("master_read", rd_w[i] & mask, din_w[i] & mask);
        end
        if (abort_bits > 0) begin
            cs_m = 1'b1;
            errq.push_back('{g, cyc + 3});
        end else if (cs_m == 1'b0) begin
            cs_m = 1'b1;
        end
        wait_n(8);
        chk("miso_idle", miso_w[g], 1'b0);
        chk("ready_idle", ready_w[g], 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, g, nw, ab;
        bit csl;
        rst    = 1'b1;
        cs_m   = 1'b1;
        sclk_m = 1'b0;
        mosi_m = 1'b0;
        sel    = 0;
        for (int i = 0; i < 3; i++) begin
            din[i]       = '0;
            model_rxd[i] = '0;
        end
        wait_n(3);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", ready_w[i], 1'b1);
            chk("rst_rx_data", rx_data_w[i], 32'h0);
            chk("rst_rx_valid", rx_valid_w[i], 1'b0);
            chk("rst_frame_err", frame_err_w[i], 1'b0);
            chk("rst_miso", miso_w[i], 1'b0);
        end
        rst = 1'b0;
        wait_n(4);

        // basic mode 0 word
        tx_w[0] = 32'h3C; din_w[0] = 32'hA5;
        v0 = nvalid;
        frame(0, 1, 0, 1'b0);
        chk("t1_read", rd_w[0], 32'hA5);
        chk("t1_rx", rx_data_w[0], 32'h3C);
        chk("t1_pulses", nvalid - v0, 1);

        // abort after 5 sample edges
        tx_w[0] = 32'h6B; din_w[0] = 32'hC3;
        v0 = nvalid; e0 = nerr;
        frame(0, 0, 5, 1'b0);
        chk("t5_rx", rx_data_w[0], 32'h3C);
        chk("t5_err_pulses", nerr - e0, 1);
        chk("t5_no_valid", nvalid - v0, 0);

        // 32-bit mode 3
        tx_w[0] = 32'h12345678; din_w[0] = 32'hDEADBEEF;
        frame(1, 1, 0, 1'b0);
        chk("t2_read", rd_w[0], 32'hDEADBEEF);
        chk("t2_rx", rx_data_w[1], 32'h12345678);

        // two words under one cs
        tx_w[0] = 32'h11; tx_w[1] = 32'h22; din_w[0] = 32'hA5; din_w[1] = 32'h5A;
        v0 = nvalid;
        frame(0, 2, 0, 1'b0);
        chk("t3_read0", rd_w[0], 32'hA5);
        chk("t3_read1", rd_w[1], 32'h5A);
        chk("t3_rx", rx_data_w[0], 32'h22);
        chk("t3_pulses", nvalid - v0, 2);

        // mode 1 LSB-first
        tx_w[0] = 32'h80; din_w[0] = 32'h01;
        frame(2, 1, 0, 1'b0);
        chk("t4_first_bit", 32'(rd_w[0][0]), 32'h1);
        chk("t4_rx", rx_data_w[2], 32'h80);

        // final sample edge coincident with cs rise
        tx_w[0] = 32'hCAFEF00D; din_w[0] = 32'h0BADC0DE;
        e0 = nerr;
        frame(1, 1, 0, 1'b1);
        chk("tsim_rx", rx_data_w[1], 32'hCAFEF00D);
        chk("tsim_no_err", nerr - e0, 0);

        // reset after 3 bits of a frame
        @(negedge clk);
        sel = 0; sclk_m = 1'b0; din[0] = 32'hA5; mosi_m = 1'b1;
        wait_n(2);
        cs_m = 1'b0;
        wait_n(8);
        for (int b = 0; b < 3; b++) begin
            sclk_m = 1'b1; wait_n(4);
            sclk_m = 1'b0; wait_n(4);
        end
        v0 = nvalid; e0 = nerr;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) model_rxd[i] = '0;
        wait_n(2);
        chk("t6_miso", miso_w[0], 1'b0);
        chk("t6_rx", rx_data_w[0], 32'h0);
        chk("t6_ready", ready_w[0], 1'b1);
        cs_m = 1'b1;
        wait_n(2);
        rst = 1'b0;
        wait_n(4);
        chk("t6_no_pulses", (nvalid - v0) + (nerr - e0), 0);
        tx_w[0] = 32'h3C; din_w[0] = 32'hA5;
        frame(0, 1, 0, 1'b0);
        chk("t6_read", rd_w[0], 32'hA5);
        chk("t6_rx_after", rx_data_w[0], 32'h3C);

        // randomised frames
        for (int n = 0; n < 30; n++) begin
            g  = $urandom_range(0, 2);
            nw = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                tx_w[i]  = $urandom;
                din_w[i] = $urandom;
            end
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (g == 1) ? 31 : 7) : 0;
            csl = CPHA_V[g] && (ab == 0) && ($urandom_range(0, 1) == 1);
            frame(g, nw, ab, csl);
        end

        wait_n(10);
        chk("rxq_drained", rxq.size(), 0);
        chk("errq_drained", errq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
